// File: rtl/imem_loader.sv
// Boot loader: turns a framed byte stream into 32-bit little-endian instruction RAM writes.
// Latency: MEM_WE rises one cycle after the 4th byte of a word is accepted; all outputs are registered.
// Backpressure: RX_READY is low outside header/data/checksum states and during each write cycle; no skid buffer.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter logic        BOOT_HOLD = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] word_cnt_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_WRITE, S_FINISH, S_ERR, S_CHK
  } state_t;
  // After the last word (or an empty frame) the trailing checksum byte is expected.
  localparam state_t S_TAIL = S_CHK;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_WRITE, S_FINISH, S_ERR
  } state_t;
  localparam state_t S_TAIL = S_FINISH;
`endif

  // One extra bit so a 16-bit count can be compared against the limit without truncation.
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  csum_q, csum_d;
  logic        rdy_q, rdy_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] n_new;
  logic        accept;

  assign accept = rx_valid_i & rdy_q;
  assign n_new  = {rx_data_i, n_q[7:0]};

  // Next state and next registered outputs; outputs are derived from the state being entered.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    lane_d  = lane_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start_i) begin
          state_d = S_HDR_LO;
          hold_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          addr_d  = BASE_ADDR;
          lane_d  = '0;
          csum_d  = '0;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          n_d     = {n_q[15:8], rx_data_i};
          csum_d  = csum_q ^ rx_data_i;
          state_d = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          n_d    = n_new;
          csum_d = csum_q ^ rx_data_i;
          if ({1'b0, n_new} > MAX_N) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end else if (n_new == 16'd0) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          wdata_d[{lane_q, 3'b000} +: 8] = rx_data_i;
          csum_d = csum_q ^ rx_data_i;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 32'd4;
        cnt_d   = cnt_q + 16'd1;
        state_d = (cnt_d < n_q) ? S_DATA : S_TAIL;
      end
      S_FINISH: state_d = S_IDLE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (rx_data_i == csum_q) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Registered outputs reflect the state entered on this edge.
    we_d   = (state_d == S_WRITE);
    rdy_d  = (state_d == S_HDR_LO) || (state_d == S_HDR_HI) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
             || (state_d == S_CHK)
`endif
             ;
    busy_d = (state_d != S_IDLE) && (state_d != S_ERR);
    done_d = (state_d == S_FINISH);
    if (state_d == S_FINISH) hold_d = 1'b0;
  end

  // State and output registers with asynchronous reset to the boot values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      lane_q  <= '0;
      csum_q  <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      hold_q  <= BOOT_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      lane_q  <= lane_d;
      csum_q  <= csum_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rx_ready_o  = rdy_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_hold_o  = hold_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = err_q;
  assign word_cnt_o  = cnt_q;

endmodule
